// File: rtl/sha_nonce_sequencer.sv
// Round/nonce sequencer for a SHA-256 mining core: 64 rounds per nonce, sticky exhaustion flag.
// Optional macro NONCE_HALT_EN freezes counting once the nonce space has been exhausted.
module sha_nonce_sequencer #(
   parameter logic [31:0] NONCE_INIT = 32'd0
) (
   input  logic        clk,
   input  logic        clearCounter,
   input  logic        solveEn,
   output logic [5:0]  cycle,
   output logic [32:0] nonce
);

   logic [5:0]  r_cycle;
   logic [31:0] r_nonce;
   logic        r_exhausted;

   logic        w_halt;
   logic        w_advance;
   logic        w_round_end;
   logic        w_nonce_last;

`ifdef NONCE_HALT_EN
   assign w_halt = r_exhausted;
`else
   assign w_halt = 1'b0;
`endif

   assign w_advance    = solveEn & ~w_halt;
   assign w_round_end  = (r_cycle == 6'd63);
   assign w_nonce_last = (r_nonce == 32'hFFFF_FFFF);

   // Reset wins over enable and over a pending round wrap.
   always_ff @(posedge clk) begin
      if (!clearCounter) begin
         r_cycle     <= 6'd0;
         r_nonce     <= NONCE_INIT;
         r_exhausted <= 1'b0;
      end else if (w_advance) begin
         r_cycle <= r_cycle + 6'd1;
         if (w_round_end) begin
            r_nonce <= r_nonce + 32'd1;
            if (w_nonce_last) begin
               r_exhausted <= 1'b1;
            end
         end
      end
   end

   assign cycle = r_cycle;
   assign nonce = {r_exhausted, r_nonce};

endmodule

// File: tb/tb_sha_nonce_sequencer.sv
// Directed bench for sha_nonce_sequencer: three instances with different NONCE_INIT share stimulus.
module tb_sha_nonce_sequencer;

   logic        clk;
   logic        clear_n;
   logic        solve_en;
   logic [5:0]  cycle_a, cycle_b, cycle_c;
   logic [32:0] nonce_a, nonce_b, nonce_c;

   int checks   = 0;
   int failures = 0;

   sha_nonce_sequencer #(.NONCE_INIT(32'd0)) dut_a (
      .clk(clk), .clearCounter(clear_n), .solveEn(solve_en), .cycle(cycle_a), .nonce(nonce_a));
   sha_nonce_sequencer #(.NONCE_INIT(32'hFFFF_FFFF)) dut_b (
      .clk(clk), .clearCounter(clear_n), .solveEn(solve_en), .cycle(cycle_b), .nonce(nonce_b));
   sha_nonce_sequencer #(.NONCE_INIT(32'h0000_1000)) dut_c (
      .clk(clk), .clearCounter(clear_n), .solveEn(solve_en), .cycle(cycle_c), .nonce(nonce_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
   task automatic step(input logic clr, input logic en);
      clear_n  = clr;
      solve_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b1);
   endtask

   initial begin
      clear_n  = 1'b0;
      solve_en = 1'b0;
      #2;

      // Reset state of all instances
      step(1'b0, 1'b1);
      check("rst_cycle_a", 64'(cycle_a), 64'd0);
      check("rst_nonce_a", 64'(nonce_a), 64'h0_0000_0000);
      check("rst_nonce_b", 64'(nonce_b), 64'h0_FFFF_FFFF);
      check("rst_nonce_c", 64'(nonce_c), 64'h0_0000_1000);

      // First enabled edge: cycle 1, nonce unchanged
      step(1'b1, 1'b1);
      check("first_cycle", 64'(cycle_a), 64'd1);
      check("first_nonce", 64'(nonce_a), 64'd0);
      for (int i = 2; i <= 63; i++) begin
         step(1'b1, 1'b1);
         check("count_cycle", 64'(cycle_a), 64'(i));
         check("count_nonce", 64'(nonce_a), 64'd0);
      end
      // 64th edge: round wraps and nonce advances
      step(1'b1, 1'b1);
      check("wrap_cycle", 64'(cycle_a), 64'd0);
      check("wrap_nonce", 64'(nonce_a), 64'd1);
      check("exhaust_nonce_b", 64'(nonce_b), 64'h1_0000_0000);
      check("c_nonce_64", 64'(nonce_c), 64'h0_0000_1001);

      // 64 further edges: exhaustion behaviour and parameter override
      run(64);
      check("a_nonce_128", 64'(nonce_a), 64'd2);
      check("a_cycle_128", 64'(cycle_a), 64'd0);
      check("c_nonce_128", 64'(nonce_c), 64'h0_0000_1002);
      check("b_cycle_128", 64'(cycle_b), 64'd0);
`ifdef NONCE_HALT_EN
      check("b_nonce_128", 64'(nonce_b), 64'h1_0000_0000);
      step(1'b1, 1'b1);
      check("b_halt_cycle", 64'(cycle_b), 64'd0);
`else
      check("b_nonce_128", 64'(nonce_b), 64'h1_0000_0001);
      step(1'b1, 1'b1);
      check("b_run_cycle", 64'(cycle_b), 64'd1);
`endif

      // Reset clears the sticky flag
      step(1'b0, 1'b0);
      check("rst2_nonce_b", 64'(nonce_b), 64'h0_FFFF_FFFF);
      check("rst2_cycle_b", 64'(cycle_b), 64'd0);

      // Enable gating: 10 enabled, 5 held, then resume
      run(10);
      check("gate_pre_cycle", 64'(cycle_a), 64'd10);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         check("gate_hold_cycle", 64'(cycle_a), 64'd10);
         check("gate_hold_nonce", 64'(nonce_a), 64'd0);
      end
      step(1'b1, 1'b1);
      check("gate_resume", 64'(cycle_a), 64'd11);

      // Mid-round reset at cycle 37 with nonce 5
      step(1'b0, 1'b0);
      run(5 * 64 + 37);
      check("mid_pre_cycle", 64'(cycle_a), 64'd37);
      check("mid_pre_nonce", 64'(nonce_a), 64'd5);
      check("mid_pre_nonce_c", 64'(nonce_c), 64'h0_0000_1005);
      step(1'b0, 1'b1);
      check("mid_rst_cycle", 64'(cycle_a), 64'd0);
      check("mid_rst_nonce", 64'(nonce_a), 64'd0);
      check("mid_rst_nonce_c", 64'(nonce_c), 64'h0_0000_1000);
      step(1'b1, 1'b1);
      check("mid_next_cycle", 64'(cycle_a), 64'd1);
      check("mid_next_nonce", 64'(nonce_a), 64'd0);

      // Reset versus wrap at cycle 63
      step(1'b0, 1'b0);
      run(63);
      check("rw_pre_cycle", 64'(cycle_a), 64'd63);
      step(1'b0, 1'b1);
      check("rw_cycle", 64'(cycle_a), 64'd0);
      check("rw_nonce", 64'(nonce_a), 64'd0);
      check("rw_nonce_b", 64'(nonce_b), 64'h0_FFFF_FFFF);
      step(1'b1, 1'b0);
      check("rw_hold_cycle", 64'(cycle_a), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
